// File: rtl/byte_serial_add32_pkg.sv
// Shared types and constants for the byte-serial 32-bit adder/subtractor.
package byte_serial_add32_pkg;

  localparam int NBYTES = 4;
  localparam int BYTEW  = 8;
  localparam int WIDTH  = NBYTES * BYTEW;
  localparam int IDXW   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/byte_serial_add32_if.sv
// Operand/result bundle between a requester and the byte-serial adder.
interface byte_serial_add32_if;
  import byte_serial_add32_pkg::*;

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (output start, sub, a, b, input busy, done, sum, cout, ovf);
  modport slave  (input start, sub, a, b, output busy, done, sum, cout, ovf);

endinterface

// File: rtl/byte_serial_add32_cla8.sv
// 8-bit carry-lookahead adder; every carry is a flat sum of generate/propagate products.
module cla8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] g_s;
  logic [7:0] p_s;
  logic [8:0] c_s;
  logic       term_s;

  assign g_s = a & b;
  assign p_s = a ^ b;

  // Each carry c[i] = OR over j<i of g[j]&p[j+1..i-1], plus cin&p[0..i-1].
  always_comb begin
    c_s    = 9'd0;
    term_s = 1'b0;
    c_s[0] = cin;
    for (int i = 1; i <= 8; i++) begin
      for (int j = 0; j < i; j++) begin
        term_s = g_s[j];
        for (int k = j + 1; k < i; k++) begin
          term_s = term_s & p_s[k];
        end
        c_s[i] = c_s[i] | term_s;
      end
      term_s = cin;
      for (int k = 0; k < i; k++) begin
        term_s = term_s & p_s[k];
      end
      c_s[i] = c_s[i] | term_s;
    end
  end

  assign sum  = p_s ^ c_s[7:0];
  assign cout = c_s[8];

endmodule

// File: rtl/byte_serial_add32.sv
// 32-bit add/subtract computed one byte per cycle through a single shared cla8.
module byte_serial_add32
  import byte_serial_add32_pkg::*;
(
  input  logic               hz100,
  input  logic               reset,
  byte_serial_add32_if.slave bus
);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] beff_r;
  logic [WIDTH-1:0] sum_r;
  logic [IDXW-1:0]  idx_r;
  logic             carry_r;
  logic             cout_r;
  logic             ovf_r;
  logic             busy_r;
  logic             done_r;
  logic             accept_s;
  logic [BYTEW-1:0] a_byte_s;
  logic [BYTEW-1:0] b_byte_s;
  logic [BYTEW-1:0] cla_sum_s;
  logic             cla_cout_s;

  cla8 u_cla8 (
    .a    (a_byte_s),
    .b    (b_byte_s),
    .cin  (carry_r),
    .sum  (cla_sum_s),
    .cout (cla_cout_s)
  );

  // Operand byte select for the current index.
  always_comb begin
    a_byte_s = a_r[7:0];
    b_byte_s = beff_r[7:0];
    case (idx_r)
      2'd0: begin a_byte_s = a_r[7:0];   b_byte_s = beff_r[7:0];   end
      2'd1: begin a_byte_s = a_r[15:8];  b_byte_s = beff_r[15:8];  end
      2'd2: begin a_byte_s = a_r[23:16]; b_byte_s = beff_r[23:16]; end
      2'd3: begin a_byte_s = a_r[31:24]; b_byte_s = beff_r[31:24]; end
      default: begin a_byte_s = a_r[7:0]; b_byte_s = beff_r[7:0]; end
    endcase
  end

  // Accept a new operation only when no byte additions are pending.
  always_comb begin
    accept_s = 1'b0;
    if ((state_r == IDLE || state_r == DONE) && bus.start) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = ADD;
        else          state_nxt_s = IDLE;
      end
      ADD: begin
        if (idx_r == 2'd3) state_nxt_s = DONE;
        else               state_nxt_s = ADD;
      end
      DONE: begin
        if (accept_s) state_nxt_s = ADD;
        else          state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Operand latch, byte-serial accumulation and registered status outputs.
  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      a_r     <= 32'd0;
      beff_r  <= 32'd0;
      sum_r   <= 32'd0;
      idx_r   <= 2'd0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s == ADD);
      done_r <= (state_nxt_s == DONE);
      if (accept_s) begin
        a_r     <= bus.a;
        beff_r  <= bus.sub ? ~bus.b : bus.b;
        carry_r <= bus.sub;
        idx_r   <= 2'd0;
      end else if (state_r == ADD) begin
        case (idx_r)
          2'd0:    sum_r[7:0]   <= cla_sum_s;
          2'd1:    sum_r[15:8]  <= cla_sum_s;
          2'd2:    sum_r[23:16] <= cla_sum_s;
          2'd3:    sum_r[31:24] <= cla_sum_s;
          default: sum_r[7:0]   <= cla_sum_s;
        endcase
        carry_r <= cla_cout_s;
        idx_r   <= idx_r + 2'd1;
        // Byte 3 carries the sign, so cout/ovf are settled on the last step.
        if (idx_r == 2'd3) begin
          cout_r <= cla_cout_s;
          ovf_r  <= (a_r[WIDTH-1] == beff_r[WIDTH-1]) & (cla_sum_s[BYTEW-1] != a_r[WIDTH-1]);
        end else begin
          cout_r <= cout_r;
          ovf_r  <= ovf_r;
        end
      end else begin
        idx_r <= idx_r;
      end
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;

endmodule

// File: doc/byte_serial_add32.md
BYTE_SERIAL_ADD32 -- requirements
Module: byte_serial_add32

Interface
REQ-001 The block SHALL use a single clock and an asynchronous, active-high reset, with all state updating on the rising edge of hz100.
REQ-002 The block SHALL provide the following ports:
- hz100  in  1  system clock
- reset  in  1  asynchronous active-high reset
- start  in  1  request a new operation (level, sampled each edge)
- sub  in  1  0 = a+b, 1 = a-b; latched with operands
- a  in  32  operand A; latched on accept
- b  in  32  operand B; latched on accept
- busy  out  1  high while byte additions are in progress
- done  out  1  one-cycle pulse when the result is complete
- sum  out  32  result, held until the next accept
- cout  out  1  carry out of bit 31 (sub: 1 = no borrow)
- ovf  out  1  two's-complement signed overflow
REQ-003 The block SHALL have no parameters and a fixed width of 32 bits, processed as 4 bytes.

Function
REQ-004 The block SHALL implement the FSM states IDLE, ADD and DONE.
REQ-005 While in IDLE or DONE, start=1 at an edge SHALL accept the operation: latch a, sub and the effective B (b when sub=0, ~b when sub=1); set the carry register to sub; set the byte index to 0; go to ADD.
REQ-006 While in ADD, start SHALL be ignored, and a, b and sub changes SHALL have no effect on the operation in progress.
REQ-007 At each ADD edge, the block SHALL:
- add byte[idx] of the latched A and effective B with the carry register through one 8-bit carry-lookahead adder;
- write the 8-bit sum to sum[8*idx+7:8*idx];
- store the adder carry-out into the carry register;
- increment idx.
REQ-008 After the ADD edge with idx=3, the FSM SHALL go to DONE; cout SHALL equal the final carry; ovf SHALL equal (A[31]==Beff[31]) & (sum[31]!=A[31]).
REQ-009 Latency: if start is accepted at edge E0, the ADD edges SHALL be E1..E4, and done SHALL be high for exactly the cycle between E4 and E5.
REQ-010 In DONE with start=0, the FSM SHALL go to IDLE at the next edge; in DONE with start=1, the operation SHALL be accepted (back-to-back, no IDLE cycle).
REQ-011 busy SHALL be 1 in ADD and 0 in IDLE and DONE; done SHALL be 1 only in DONE.
REQ-012 sum, cout and ovf SHALL hold their last completed values in IDLE and DONE; during ADD, upper sum bytes not yet written are undefined to the consumer and SHALL be treated as invalid until done.
REQ-013 Byte wrap-around SHALL follow two's-complement rules: the carry out of byte 3 leaves only through cout; no carry enters byte 0 except the initial value sub.

Reset
REQ-014 Reset SHALL force the following, asynchronously:
- state = IDLE;
- idx = 0;
- carry register = 0;
- latched operands = 0;
- sum = 0, cout = 0, ovf = 0, busy = 0, done = 0.
REQ-015 Reset asserted mid-ADD SHALL abandon the operation with no done pulse; after reset deasserts, the first start SHALL be accepted normally.

Structure
REQ-016 A shared package SHALL hold the FSM state enum (IDLE, ADD, DONE) and the constants NBYTES=4 and BYTEW=8.
REQ-017 The block SHALL instantiate exactly one team-library 8-bit carry-lookahead adder sub-module, cla8, for all byte additions; the block SHALL contain no other adder.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- a=0x000000FF, b=0x00000001, sub=0 -> sum=0x00000100, cout=0, ovf=0, done high only in the cycle after E4.
- a=0xFFFFFFFF, b=0x00000001, sub=0 -> sum=0x00000000, cout=1, ovf=0.
- a=0x7FFFFFFF, b=0x00000001, sub=0 -> sum=0x80000000, cout=0, ovf=1.
- a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0; then a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, ovf=1.
- start pulsed at E2 during ADD with new operands -> ignored, first result unchanged; start held high through DONE -> second operation accepted at E4+1, with done pulses 5 cycles apart.
- reset asserted between E2 and E3 -> all outputs 0 immediately, no done pulse; next start completes correctly.
